// File: rtl/decode_disp_imm_collector.sv
// rtl/decode_disp_imm_collector.sv - multi-cycle displacement/immediate byte collector
module decode_disp_imm_collector #(
  parameter int FETCH_BYTES = 8,
  parameter int BUF_BYTES   = 8,
  localparam int CW         = $clog2(FETCH_BYTES + 1)
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_flush,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [3:0]               i_req_disp_length,
  input  logic                     i_req_disp_sext,
  input  logic [3:0]               i_req_imm_length,
  input  logic                     i_req_imm_sext,
  input  logic [8*FETCH_BYTES-1:0] i_fetch_data,
  input  logic [CW-1:0]            i_fetch_count,
  output logic [CW-1:0]            o_fetch_consume,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [31:0]              o_displacement,
  output logic [31:0]              o_immediate,
  output logic [3:0]               o_bytes_consumed
);

  localparam int HW = $clog2(BUF_BYTES + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             disp_n_q, disp_n_d, imm_n_q, imm_n_d;
  logic                   disp_sext_q, disp_sext_d, imm_sext_q, imm_sext_d;
  logic [HW-1:0]          have_q, have_d;
  logic [8*BUF_BYTES-1:0] buf_q, buf_d;
  logic [31:0]            disp_q, disp_d, imm_q, imm_d;
  logic [3:0]             bytes_q, bytes_d;

  logic [HW-1:0]          need, new_need;
  logic [31:0]            imm_raw;
  logic                   req_fire;
  int                     rem_i, take_i, off_i;

  // Lowest set bit wins; the "full" encoding collects four bytes like the 32-bit one.
  function automatic logic [2:0] len_bytes(input logic [3:0] onehot);
    if (onehot[0])      return 3'd1;
    else if (onehot[1]) return 3'd2;
    else if (onehot[2]) return 3'd4;
    else if (onehot[3]) return 3'd4;
    else                return 3'd0;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] n,
                                         input logic sext);
    case (n)
      3'd1:    return {{24{raw[7] & sext}}, raw[7:0]};
      3'd2:    return {{16{raw[15] & sext}}, raw[15:0]};
      3'd4:    return raw;
      default: return 32'd0;
    endcase
  endfunction

  assign o_req_ready      = (state_q == S_IDLE) || ((state_q == S_DONE) && i_ready);
  assign o_valid          = (state_q == S_DONE);
  assign o_displacement   = disp_q;
  assign o_immediate      = imm_q;
  assign o_bytes_consumed = bytes_q;

  always_comb begin
    state_d         = state_q;
    disp_n_d        = disp_n_q;
    imm_n_d         = imm_n_q;
    disp_sext_d     = disp_sext_q;
    imm_sext_d      = imm_sext_q;
    have_d          = have_q;
    buf_d           = buf_q;
    disp_d          = disp_q;
    imm_d           = imm_q;
    bytes_d         = bytes_q;
    o_fetch_consume = '0;
    imm_raw         = '0;
    off_i           = 0;

    need     = HW'(disp_n_q) + HW'(imm_n_q);
    new_need = HW'(len_bytes(i_req_disp_length)) + HW'(len_bytes(i_req_imm_length));
    rem_i    = int'(need) - int'(have_q);
    take_i   = (int'(i_fetch_count) < rem_i) ? int'(i_fetch_count) : rem_i;
    req_fire = i_req_valid && o_req_ready && !i_flush;

    if (i_flush) begin
      state_d = S_IDLE;
      have_d  = '0;
    end else if (req_fire) begin
      disp_n_d    = len_bytes(i_req_disp_length);
      imm_n_d     = len_bytes(i_req_imm_length);
      disp_sext_d = i_req_disp_sext;
      imm_sext_d  = i_req_imm_sext;
      have_d      = '0;
      buf_d       = '0;
      if (new_need == '0) begin
        state_d = S_DONE;
        disp_d  = '0;
        imm_d   = '0;
        bytes_d = '0;
      end else begin
        state_d = S_COLLECT;
      end
    end else if (state_q == S_COLLECT) begin
      o_fetch_consume = CW'(take_i);
      for (int i = 0; i < BUF_BYTES; i++) begin
        off_i = i - int'(have_q);
        if (off_i >= 0 && off_i < take_i && off_i < FETCH_BYTES)
          buf_d[i*8 +: 8] = i_fetch_data[off_i*8 +: 8];
      end
      have_d = have_q + HW'(take_i);
      if (have_d == need) begin
        // Immediate bytes sit directly after the displacement bytes.
        imm_raw = 32'(buf_d >> {disp_n_q, 3'b000});
        state_d = S_DONE;
        disp_d  = extend(buf_d[31:0], disp_n_q, disp_sext_q);
        imm_d   = extend(imm_raw, imm_n_q, imm_sext_q);
        bytes_d = 4'(need);
      end
    end else if (state_q == S_DONE && i_ready) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      disp_n_q    <= '0;
      imm_n_q     <= '0;
      disp_sext_q <= 1'b0;
      imm_sext_q  <= 1'b0;
      have_q      <= '0;
      buf_q       <= '0;
      disp_q      <= '0;
      imm_q       <= '0;
      bytes_q     <= '0;
    end else begin
      state_q     <= state_d;
      disp_n_q    <= disp_n_d;
      imm_n_q     <= imm_n_d;
      disp_sext_q <= disp_sext_d;
      imm_sext_q  <= imm_sext_d;
      have_q      <= have_d;
      buf_q       <= buf_d;
      disp_q      <= disp_d;
      imm_q       <= imm_d;
      bytes_q     <= bytes_d;
    end
  end

endmodule
